i2c_oled_target: RTL

I2C_OLED_TARGET -- requirements
Module: i2c_oled_target

---
 rtl/oled_i2c_pkg.sv | 31 +++
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_oled_target.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/oled_i2c_pkg.sv
// +----------------------------------------------------------------------------+
// | oled_i2c_pkg : shared types and constants for the OLED I2C target           |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package oled_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ADDR        = 3'd1,
    ST_ADDR_ACK    = 3'd2,
    ST_CTRL        = 3'd3,
    ST_CTRL_ACK    = 3'd4,
    ST_PAYLOAD     = 3'd5,
    ST_PAYLOAD_ACK = 3'd6,
    ST_IGNORE      = 3'd7
  } state_t;

  localparam logic [6:0] C_ADDR0_DEFAULT = 7'h3C;
  localparam logic [6:0] C_ADDR1_DEFAULT = 7'h3D;

  // Control byte layout: Co = continuation, D/C# = data/command select.
  localparam int unsigned C_CO_BIT = 7;
  localparam int unsigned C_DC_BIT = 6;

  localparam logic [8:0] C_COUNT_MAX = 9'd511;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// +----------------------------------------------------------------------------+
// | i2c_bus_sync : SCL/SDA synchroniser, SCL edge and START/STOP detection      |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  // Idle bus level is high, so every stage resets to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  assign scl      = r_scl_sync[1];
  assign sda      = r_sda_sync[1];
  assign scl_rise =  scl & ~r_scl_d;
  assign scl_fall = ~scl &  r_scl_d;
  assign start    =  scl & r_sda_d & ~sda;
  assign stop     =  scl & ~r_sda_d & sda;

endmodule

`default_nettype wire

// File: rtl/i2c_oled_target.sv
// +----------------------------------------------------------------------------+
// | i2c_oled_target : write-only I2C target decoding SSD1306-style frames       |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_oled_target
  import oled_i2c_pkg::*;
#(
  parameter logic [6:0] ADDR0 = C_ADDR0_DEFAULT,
  parameter logic [6:0] ADDR1 = C_ADDR1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       addr_sel,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic [8:0] byte_count,
  output logic       busy
);

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shreg;
  logic [6:0] r_addr;
  logic       r_co;
  logic       r_dc;
  logic       r_ack_on;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl      (w_scl),
    .sda      (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  assign w_byte = {r_shreg, w_sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shreg      <= 7'd0;
      r_addr       <= ADDR0;
      r_co         <= 1'b0;
      r_dc         <= 1'b0;
      r_ack_on     <= 1'b0;
      sda_oe       <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'd0;
      byte_is_data <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      byte_count   <= 9'd0;
      busy         <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      // Bus conditions override any bit activity and drop a partial byte.
      if (w_start || w_stop) begin
        r_state   <= w_start ? ST_ADDR : ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_ack_on  <= 1'b0;
        sda_oe    <= 1'b0;
        if (w_start) r_addr <= addr_sel ? ADDR1 : ADDR0;
        if (busy) begin
          frame_end <= 1'b1;
          busy      <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_ADDR, ST_CTRL, ST_PAYLOAD: begin
            if (w_scl_rise) begin
              r_shreg   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ST_ADDR) begin
                  if (w_byte[7:1] == r_addr && !w_byte[0]) begin
                    r_state     <= ST_ADDR_ACK;
                    frame_start <= 1'b1;
                    busy        <= 1'b1;
                    byte_count  <= 9'd0;
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end else if (r_state == ST_CTRL) begin
                  r_co    <= w_byte[C_CO_BIT];
                  r_dc    <= w_byte[C_DC_BIT];
                  r_state <= ST_CTRL_ACK;
                end else begin
                  byte_valid   <= 1'b1;
                  byte_data    <= w_byte;
                  byte_is_data <= r_dc;
                  if (byte_count != C_COUNT_MAX) byte_count <= byte_count + 9'd1;
                  r_state      <= ST_PAYLOAD_ACK;
                end
              end
            end
          end
          // First SCL fall after bit 8 starts driving ACK, the next one ends it.
          ST_ADDR_ACK, ST_CTRL_ACK, ST_PAYLOAD_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_ack_on <= 1'b1;
                sda_oe   <= 1'b1;
              end else begin
                r_ack_on <= 1'b0;
                sda_oe   <= 1'b0;
                if (r_state == ST_ADDR_ACK)      r_state <= ST_CTRL;
                else if (r_state == ST_CTRL_ACK) r_state <= ST_PAYLOAD;
                else                             r_state <= r_co ? ST_CTRL : ST_PAYLOAD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
